// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_unit
//  Purpose  : LEGv8 single-cycle front end. Holds the PC, fetches 32-bit
//             instructions over a req/ack handshake, presents the instruction
//             and its 11-bit opcode to decode, and selects the next PC from
//             Branch/Uncondbranch/Zero.
//  Options  : FETCH_STALL_COUNT_EN - adds a saturating 32-bit StallCount
//             output counting FETCH cycles without IMemAck.
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int ADDR_W  = 64,
    parameter int PC_STEP = 4
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic [ADDR_W-1:0] StartPC,
    output logic              IMemReq,
    output logic [ADDR_W-1:0] IMemAddr,
    input  logic              IMemAck,
    input  logic [31:0]       IMemData,
    output logic [31:0]       Instruction,
    output logic [10:0]       Opcode,
    output logic              InstValid,
    input  logic              InstAccept,
    input  logic              Branch,
    input  logic              Uncondbranch,
    input  logic              Zero,
    input  logic [ADDR_W-1:0] BranchOffset,
    output logic [ADDR_W-1:0] CurrentPC
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [31:0]       StallCount
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] branch_disp;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] target_pc;
    logic [ADDR_W-1:0] next_pc;
    logic              taken;

    // The fetch address is by definition the PC of the instruction in flight.
    assign IMemAddr = CurrentPC;

    // Opcode is a pure slice, so it follows Instruction through reset.
    assign Opcode = Instruction[31:21];

    // Next-PC datapath; only consumed in the EXEC accept cycle. The word
    // offset is shifted to bytes in ADDR_W bits, dropping its top two bits,
    // and all additions wrap modulo 2^ADDR_W.
    always_comb begin
        branch_disp = BranchOffset << 2;
        seq_pc      = CurrentPC + ADDR_W'(PC_STEP);
        target_pc   = CurrentPC + branch_disp;
        taken       = Uncondbranch | (Branch & Zero);
        next_pc     = taken ? target_pc : seq_pc;
    end

    // Fetch/execute sequencer with registered handshake outputs.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state       <= ST_IDLE;
            CurrentPC   <= '0;
            IMemReq     <= 1'b0;
            Instruction <= '0;
            InstValid   <= 1'b0;
        end else begin
            case (state)
                // One cycle after reset release: load the start address and
                // raise the request so it is visible on the next cycle.
                ST_IDLE: begin
                    CurrentPC <= StartPC;
                    IMemReq   <= 1'b1;
                    state     <= ST_FETCH;
                end
                // Wait indefinitely for memory; InstAccept is ignored here.
                ST_FETCH: begin
                    if (IMemAck) begin
                        Instruction <= IMemData;
                        InstValid   <= 1'b1;
                        IMemReq     <= 1'b0;
                        state       <= ST_EXEC;
                    end
                end
                // Hold the instruction stable until the datapath retires it;
                // IMemAck is ignored here.
                ST_EXEC: begin
                    if (InstAccept) begin
                        InstValid <= 1'b0;
                        IMemReq   <= 1'b1;
                        CurrentPC <= next_pc;
                        state     <= ST_FETCH;
                    end
                end
                default: begin
                    IMemReq   <= 1'b0;
                    InstValid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    // Count FETCH cycles spent waiting on memory, saturating at all-ones.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            StallCount <= '0;
        end else if ((state == ST_FETCH) && !IMemAck && (StallCount != 32'hFFFF_FFFF)) begin
            StallCount <= StallCount + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch_unit
//  Purpose  : Self-checking bench for instruction_fetch_unit. Expected fetch
//             addresses and instruction words are queued when stimulus is
//             driven and popped when the DUT presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam int ADDR_W = 64;

    logic              CLK = 1'b0;
    logic              Reset_L;
    logic [ADDR_W-1:0] StartPC;
    logic              IMemReq;
    logic [ADDR_W-1:0] IMemAddr;
    logic              IMemAck;
    logic [31:0]       IMemData;
    logic [31:0]       Instruction;
    logic [10:0]       Opcode;
    logic              InstValid;
    logic              InstAccept;
    logic              Branch;
    logic              Uncondbranch;
    logic              Zero;
    logic [ADDR_W-1:0] BranchOffset;
    logic [ADDR_W-1:0] CurrentPC;
`ifdef FETCH_STALL_COUNT_EN
    logic [31:0]       StallCount;
`endif

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] addr_q[$];
    logic [31:0]       inst_q[$];

    instruction_fetch_unit #(.ADDR_W(ADDR_W), .PC_STEP(4)) dut (
        .CLK          (CLK),
        .Reset_L      (Reset_L),
        .StartPC      (StartPC),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemAck      (IMemAck),
        .IMemData     (IMemData),
        .Instruction  (Instruction),
        .Opcode       (Opcode),
        .InstValid    (InstValid),
        .InstAccept   (InstAccept),
        .Branch       (Branch),
        .Uncondbranch (Uncondbranch),
        .Zero         (Zero),
        .BranchOffset (BranchOffset),
        .CurrentPC    (CurrentPC)
`ifdef FETCH_STALL_COUNT_EN
        ,
        .StallCount   (StallCount)
`endif
    );

    always #5 CLK = ~CLK;

    // Inputs change and outputs are observed on the falling edge.
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        IMemAck      = 1'b0;
        IMemData     = '0;
        InstAccept   = 1'b0;
        Branch       = 1'b0;
        Uncondbranch = 1'b0;
        Zero         = 1'b0;
        BranchOffset = '0;
    endtask

    // Reset for two cycles, release, and queue the start address as the
    // first expected fetch.
    task automatic apply_reset(input logic [ADDR_W-1:0] start);
        Reset_L = 1'b0;
        clear_inputs();
        StartPC = start;
        tick();
        tick();
        addr_q.delete();
        inst_q.delete();
        Reset_L = 1'b1;
        addr_q.push_back(start);
    endtask

    task automatic drive_ack(input logic [31:0] word);
        IMemAck  = 1'b1;
        IMemData = word;
        inst_q.push_back(word);
        tick();
        IMemAck  = 1'b0;
        IMemData = 32'hDEAD_BEEF;
    endtask

    task automatic drive_accept(input logic br, input logic ubr, input logic z,
                                input logic [ADDR_W-1:0] off, input logic [ADDR_W-1:0] nxt);
        InstAccept   = 1'b1;
        Branch       = br;
        Uncondbranch = ubr;
        Zero         = z;
        BranchOffset = off;
        addr_q.push_back(nxt);
        tick();
        InstAccept   = 1'b0;
        Branch       = 1'b0;
        Uncondbranch = 1'b0;
        Zero         = 1'b0;
        BranchOffset = 64'hFFFF_0000_FFFF_0000;
    endtask

    task automatic test_reset();
        logic [ADDR_W-1:0] ea;
        logic [31:0]       ei;
        Reset_L = 1'b0;
        clear_inputs();
        StartPC = 64'h100;
        tick();
        tick();
        checks++;
        if (IMemReq !== 1'b0 || InstValid !== 1'b0 || Instruction !== 32'h0 ||
            Opcode !== 11'h0 || CurrentPC !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: req=%b valid=%b inst=%h opc=%h pc=%h want 0/0/0/0/0",
                     IMemReq, InstValid, Instruction, Opcode, CurrentPC);
        end
        Reset_L = 1'b1;
        addr_q.push_back(64'h100);
        tick();
        ea = addr_q.pop_front();
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== ea || InstValid !== 1'b0) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h valid=%b want 1 %h 0", IMemReq, IMemAddr, InstValid, ea);
        end
`ifdef FETCH_STALL_COUNT_EN
        checks++;
        if (StallCount !== 32'd0) begin
            errors++;
            $display("FAIL stall_reset: got %0d want 0", StallCount);
        end
`endif
        drive_ack(32'h8B02_0020);
        ei = inst_q.pop_front();
        checks++;
        if (InstValid !== 1'b1 || IMemReq !== 1'b0 || Instruction !== ei || Opcode !== ei[31:21]) begin
            errors++;
            $display("FAIL first_inst: valid=%b req=%b inst=%h opc=%h want 1 0 %h %h",
                     InstValid, IMemReq, Instruction, Opcode, ei, ei[31:21]);
        end
    endtask

    // Entered in EXEC at 0x100; four sequential retirements reach 0x110.
    task automatic test_sequential();
        logic [ADDR_W-1:0] ea;
        logic [31:0]       ei;
        for (int i = 0; i < 4; i++) begin
            drive_accept(1'b0, 1'b0, 1'b0, 64'h7, 64'h104 + 64'(4 * i));
            ea = addr_q.pop_front();
            checks++;
            if (IMemReq !== 1'b1 || IMemAddr !== ea || InstValid !== 1'b0) begin
                errors++;
                $display("FAIL seq_addr[%0d]: req=%b addr=%h valid=%b want 1 %h 0", i, IMemReq, IMemAddr, InstValid, ea);
            end
            if (i < 3) begin
                drive_ack(32'hF840_0000 + 32'(i));
                ei = inst_q.pop_front();
                checks++;
                if (InstValid !== 1'b1 || Instruction !== ei || Opcode !== ei[31:21]) begin
                    errors++;
                    $display("FAIL seq_inst[%0d]: valid=%b inst=%h opc=%h want 1 %h", i, InstValid, Instruction, Opcode, ei);
                end
            end
        end
    endtask

    // Entered in FETCH at 0x110: CBZ taken back to 0x108, walk to 0x110,
    // then CBZ not taken to 0x114.
    task automatic test_cbz();
        logic [ADDR_W-1:0] ea;
        logic [31:0]       ei;
        logic [ADDR_W-1:0] nxt [4] = '{64'h108, 64'h10C, 64'h110, 64'h114};
        logic              brv [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic              zv  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive_ack(32'hB400_0040 + 32'(i));
            ei = inst_q.pop_front();
            checks++;
            if (InstValid !== 1'b1 || Instruction !== ei) begin
                errors++;
                $display("FAIL cbz_inst[%0d]: valid=%b inst=%h want 1 %h", i, InstValid, Instruction, ei);
            end
            drive_accept(brv[i], 1'b0, zv[i], 64'hFFFF_FFFF_FFFF_FFFE, nxt[i]);
            ea = addr_q.pop_front();
            checks++;
            if (IMemReq !== 1'b1 || IMemAddr !== ea) begin
                errors++;
                $display("FAIL cbz_addr[%0d]: req=%b addr=%h want 1 %h", i, IMemReq, IMemAddr, ea);
            end
        end
    endtask

    task automatic test_uncond_branch();
        logic [ADDR_W-1:0] ea;
        apply_reset(64'h200);
        tick();
        ea = addr_q.pop_front();
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== ea) begin
            errors++;
            $display("FAIL b_start: req=%b addr=%h want 1 %h", IMemReq, IMemAddr, ea);
        end
        drive_ack(32'h1400_0010);
        void'(inst_q.pop_front());
        drive_accept(1'b0, 1'b1, 1'b0, 64'h10, 64'h240);
        ea = addr_q.pop_front();
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== ea || CurrentPC !== ea) begin
            errors++;
            $display("FAIL b_target: req=%b addr=%h pc=%h want 1 %h", IMemReq, IMemAddr, CurrentPC, ea);
        end
    endtask

    task automatic test_stall_and_reset();
        logic [ADDR_W-1:0] ea;
        logic [31:0]       ei;
        apply_reset(64'h300);
        tick();
        ea = addr_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (IMemReq !== 1'b1 || IMemAddr !== ea || InstValid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: req=%b addr=%h valid=%b want 1 %h 0", i, IMemReq, IMemAddr, InstValid, ea);
            end
        end
`ifdef FETCH_STALL_COUNT_EN
        checks++;
        if (StallCount !== 32'd5) begin
            errors++;
            $display("FAIL stall_count: got %0d want 5", StallCount);
        end
`endif
        // Asynchronous abort while the fetch is still outstanding.
        Reset_L = 1'b0;
        StartPC = 64'h400;
        #1;
        checks++;
        if (IMemReq !== 1'b0 || InstValid !== 1'b0 || CurrentPC !== 64'h0) begin
            errors++;
            $display("FAIL async_reset: req=%b valid=%b pc=%h want 0 0 0", IMemReq, InstValid, CurrentPC);
        end
        tick();
        Reset_L = 1'b1;
        addr_q.push_back(64'h400);
        tick();
        ea = addr_q.pop_front();
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== ea) begin
            errors++;
            $display("FAIL restart_addr: req=%b addr=%h want 1 %h", IMemReq, IMemAddr, ea);
        end
        drive_ack(32'hCAFE_0001);
        ei = inst_q.pop_front();
        checks++;
        if (InstValid !== 1'b1 || Instruction !== ei) begin
            errors++;
            $display("FAIL restart_inst: valid=%b inst=%h want 1 %h", InstValid, Instruction, ei);
        end
`ifdef FETCH_STALL_COUNT_EN
        checks++;
        if (StallCount !== 32'd0) begin
            errors++;
            $display("FAIL stall_cleared: got %0d want 0", StallCount);
        end
`endif
    endtask

    task automatic test_wrap_and_spurious();
        logic [ADDR_W-1:0] ea;
        logic [31:0]       ei;
        apply_reset(64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        ea = addr_q.pop_front();
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== ea) begin
            errors++;
            $display("FAIL wrap_start: req=%b addr=%h want 1 %h", IMemReq, IMemAddr, ea);
        end
        drive_ack(32'h9100_0421);
        ei = inst_q.pop_front();
        // Spurious ack while executing must not replace the instruction.
        IMemAck  = 1'b1;
        IMemData = 32'h1234_5678;
        tick();
        IMemAck  = 1'b0;
        checks++;
        if (InstValid !== 1'b1 || IMemReq !== 1'b0 || Instruction !== ei ||
            CurrentPC !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("FAIL spurious_ack: valid=%b req=%b inst=%h pc=%h want 1 0 %h fffffffffffffffc",
                     InstValid, IMemReq, Instruction, CurrentPC, ei);
        end
        drive_accept(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        ea = addr_q.pop_front();
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== ea) begin
            errors++;
            $display("FAIL wrap_addr: req=%b addr=%h want 1 %h", IMemReq, IMemAddr, ea);
        end
        // Spurious accept with a taken branch while fetching must be ignored.
        InstAccept   = 1'b1;
        Uncondbranch = 1'b1;
        BranchOffset = 64'h40;
        tick();
        InstAccept   = 1'b0;
        Uncondbranch = 1'b0;
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== 64'h0 || InstValid !== 1'b0) begin
            errors++;
            $display("FAIL spurious_accept: req=%b addr=%h valid=%b want 1 0 0", IMemReq, IMemAddr, InstValid);
        end
        // Offset top bits are discarded by the word-to-byte shift.
        drive_ack(32'h1400_0001);
        void'(inst_q.pop_front());
        drive_accept(1'b0, 1'b1, 1'b0, 64'h4000_0000_0000_0001, 64'h4);
        ea = addr_q.pop_front();
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== ea) begin
            errors++;
            $display("FAIL offset_shift: req=%b addr=%h want 1 %h", IMemReq, IMemAddr, ea);
        end
    endtask

    initial begin
        Reset_L = 1'b0;
        StartPC = '0;
        clear_inputs();
        test_reset();
        test_sequential();
        test_cbz();
        test_uncond_branch();
        test_stall_and_reset();
        test_wrap_and_spurious();
        checks++;
        if (addr_q.size() != 0 || inst_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: addr_q=%0d inst_q=%0d want 0 0", addr_q.size(), inst_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
